scancode_converter: RTL and testbench
=====================================

Name: scancode_converter

Overview:
- Upstream neighbour of the keycode-to-ASCII stage.
- Consumes raw PS/2 scancode-set-2 bytes from the PS/2 receiver and strips the E0/F0/E1 prefixes.
- Translates each complete make or break sequence into one internal keycode strobe (key_data_stb, key_broken, key_data).
- Its outputs connect directly to the ASCII converter's key_data_stb / key_broken / key_data inputs.

Parameters:
- PREFIX_TIMEOUT, 24'd2_500_000, clock cycles allowed between a prefix byte and the next byte before the sequence is abandoned (50 ms at 50 MHz).
- PAUSE_SKIP, 3'd7, number of bytes swallowed after an E1 prefix.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- ps2_data_stb  in  1  one-cycle strobe: ps2_data holds a new received byte.
- ps2_data  in  8  received scancode byte.
- ps2_err  in  1  one-cycle strobe: parity or framing error on the byte just received.
- key_data_stb  out  1  one-cycle strobe: a new keycode is valid.
- key_broken  out  1  1 = key released (break), 0 = key pressed (make); valid with key_data_stb.
- key_data  out  8  internal keycode; valid with key_data_stb.
- seq_dropped  out  1  one-cycle pulse when a sequence is abandoned (timeout or error).

Behaviour:
- Reset values (rst is asynchronous, active-high): key_data_stb=0, key_broken=0, key_data=8'h00, seq_dropped=0, state=IDLE, timeout counter=0, skip counter=0.
- States: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (skipping the rest of an E1 sequence).
- From IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, skip counter=PAUSE_SKIP.
  - AA, FA, EE, FE, 00, FF -> ignored, stay IDLE.
  - Any other byte -> look up as a make code.
- From EXT: F0 -> EXT_BRK; any other byte -> extended make lookup, then IDLE.
- From BRK: byte -> plain break lookup, then IDLE.
- From EXT_BRK: byte -> extended break lookup, then IDLE.
- From PAUSE: each byte decrements the skip counter; when it reaches 0 -> IDLE. No keycode is ever emitted for Pause.
- Lookup:
  - A hit produces key_data_stb=1 on the cycle after the final byte's ps2_data_stb (latency 1), with key_data=keycode and key_broken=1 for BRK or EXT_BRK.
  - A miss produces no strobe; the state still returns to IDLE.
  - key_data and key_broken hold their values until the next hit.
- Extended fake-shift bytes E0 12 and E0 59 (and their breaks) are misses.
- Keycode map (plain set-2 -> keycode):
  - Letters: 1C->01 (A) … 1A->1A (Z); full table in package; e.g. 33->08 (H).
  - Digits: 45->1B (0), 16->1C (1) … 46->24 (9).
  - 0E->25, 4E->26, 55->27, 5D->28, 66->29 (BS), 29->2A (SP), 58->2C (CAPS).
  - 12 and 59 ->2D (shift); 14->2E (ctrl); 11->2F (alt); 5A->30 (enter).
  - 54->4E, 5B->4F, 4C->50, 52->51, 41->52, 49->53, 4A->54.
  - Keypad: 7C->55, 7B->56, 79->57, 71->58.
- Extended map: E0 14->2E, E0 11->2F, E0 5A->30, E0 4A->59.
- Timeout: in EXT, BRK or EXT_BRK the counter increments every cycle without ps2_data_stb. At PREFIX_TIMEOUT-1 -> IDLE and pulse seq_dropped. The counter clears on any byte.
- Error: ps2_err in any state -> IDLE, pulse seq_dropped, no key emitted. If ps2_err and ps2_data_stb are both high in the same cycle, the error wins and the byte is discarded.
- ps2_data_stb is sampled only while high; back-to-back strobes on consecutive cycles must be handled with no bytes lost.
- Reset asserted mid-sequence discards the partial sequence; no strobe is produced after release.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined:
  - A last_make register (8 bits, reset 8'h00) records the keycode of the most recent emitted make.
  - A make whose keycode equals last_make is suppressed (no strobe).
  - Any break whose keycode equals last_make clears last_make to 00; that break is still emitted.
- Undefined: every typematic repeat make is emitted as a normal make strobe.

Decomposition:
- Package ps2_kbd_pkg holds:
  - prefix constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1;
  - the ignored-byte constants;
  - the state enum;
  - keycode constants (KC_SHIFT=8'h2D, KC_CTRL=8'h2E, KC_ALT=8'h2F, KC_CAPS=8'h2C, KC_INVALID=8'h00), shared with the ASCII converter.
- One sub-module, scancode_lut: purely combinational; inputs ext flag and byte; outputs an 8-bit keycode with 00 meaning miss. The state machine, counters and output registers stay in scancode_converter.

Test Plan:
- Byte 1C -> one cycle later key_data_stb=1, key_data=01, key_broken=0; then F0 1C -> stb, key_data=01, key_broken=1.
- E0 11 then E0 F0 11 -> two strobes: key_data=2F with key_broken=0, then key_data=2F with key_broken=1.
- E1 14 77 E1 F0 14 F0 77 followed by 16 -> no strobe during the Pause sequence, then key_data=1C.
- E0, then PREFIX_TIMEOUT cycles idle -> seq_dropped pulse; then 33 -> key_data=08 (not treated as extended).
- F0 with ps2_err on the next byte -> seq_dropped, no strobe; then 29 -> key_data=2A, key_broken=0.
- With TYPEMATIC_FILTER_EN, bytes 12 12 12 F0 12 12 -> strobes: 2D make, 2D break, 2D make. Without the macro -> five strobes.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 keyboard definitions: set-2 prefix bytes, ignored controller
// bytes, converter states and the internal keycodes used by the ASCII stage.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Controller replies and error bytes that never form part of a key sequence
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_ECHO     = 8'hEE;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] SC_OVERRUN0 = 8'h00;
  localparam logic [7:0] SC_OVERRUN1 = 8'hFF;

  localparam logic [7:0] KC_INVALID = 8'h00;
  localparam logic [7:0] KC_CAPS    = 8'h2C;
  localparam logic [7:0] KC_SHIFT   = 8'h2D;
  localparam logic [7:0] KC_CTRL    = 8'h2E;
  localparam logic [7:0] KC_ALT     = 8'h2F;
  localparam logic [7:0] KC_ENTER   = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_e;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_OVERRUN0) || (b == SC_OVERRUN1);
  endfunction

endpackage

// File: rtl/scancode_lut.sv
// Combinational set-2 to internal keycode lookup; KC_INVALID (00) means miss.
module scancode_lut
  import ps2_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic [7:0] keycode
);

  always_comb begin
    // NOTE: default first so every path assigns keycode and no latch is inferred.
    keycode = KC_INVALID;
    if (ext) begin
      // Extended fake-shift bytes (E0 12, E0 59) fall through as misses
      unique case (code)
        8'h14:   keycode = KC_CTRL;
        8'h11:   keycode = KC_ALT;
        8'h5A:   keycode = KC_ENTER;
        8'h4A:   keycode = 8'h59;
        default: keycode = KC_INVALID;
      endcase
    end else begin
      unique case (code)
        8'h1C: keycode = 8'h01; 8'h32: keycode = 8'h02; 8'h21: keycode = 8'h03;
        8'h23: keycode = 8'h04; 8'h24: keycode = 8'h05; 8'h2B: keycode = 8'h06;
        8'h34: keycode = 8'h07; 8'h33: keycode = 8'h08; 8'h43: keycode = 8'h09;
        8'h3B: keycode = 8'h0A; 8'h42: keycode = 8'h0B; 8'h4B: keycode = 8'h0C;
        8'h3A: keycode = 8'h0D; 8'h31: keycode = 8'h0E; 8'h44: keycode = 8'h0F;
        8'h4D: keycode = 8'h10; 8'h15: keycode = 8'h11; 8'h2D: keycode = 8'h12;
        8'h1B: keycode = 8'h13; 8'h2C: keycode = 8'h14; 8'h3C: keycode = 8'h15;
        8'h2A: keycode = 8'h16; 8'h1D: keycode = 8'h17; 8'h22: keycode = 8'h18;
        8'h35: keycode = 8'h19; 8'h1A: keycode = 8'h1A;
        8'h45: keycode = 8'h1B; 8'h16: keycode = 8'h1C; 8'h1E: keycode = 8'h1D;
        8'h26: keycode = 8'h1E; 8'h25: keycode = 8'h1F; 8'h2E: keycode = 8'h20;
        8'h36: keycode = 8'h21; 8'h3D: keycode = 8'h22; 8'h3E: keycode = 8'h23;
        8'h46: keycode = 8'h24;
        8'h0E: keycode = 8'h25; 8'h4E: keycode = 8'h26; 8'h55: keycode = 8'h27;
        8'h5D: keycode = 8'h28; 8'h66: keycode = 8'h29; 8'h29: keycode = 8'h2A;
        8'h58: keycode = KC_CAPS;
        8'h12, 8'h59: keycode = KC_SHIFT;
        8'h14: keycode = KC_CTRL;  8'h11: keycode = KC_ALT;
        8'h5A: keycode = KC_ENTER;
        8'h54: keycode = 8'h4E; 8'h5B: keycode = 8'h4F; 8'h4C: keycode = 8'h50;
        8'h52: keycode = 8'h51; 8'h41: keycode = 8'h52; 8'h49: keycode = 8'h53;
        8'h4A: keycode = 8'h54;
        8'h7C: keycode = 8'h55; 8'h7B: keycode = 8'h56; 8'h79: keycode = 8'h57;
        8'h71: keycode = 8'h58;
        default: keycode = KC_INVALID;
      endcase
    end
  end

endmodule

// File: rtl/scancode_converter.sv
// Strips E0/F0/E1 prefixes from set-2 bytes and emits one keycode strobe per
// make/break. Define TYPEMATIC_FILTER_EN to suppress auto-repeat makes.
module scancode_converter
  import ps2_kbd_pkg::*;
#(
  parameter logic [23:0] PREFIX_TIMEOUT = 24'd2_500_000,
  parameter logic [2:0]  PAUSE_SKIP     = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_data_stb,
  input  logic [7:0] ps2_data,
  input  logic       ps2_err,
  output logic       key_data_stb,
  output logic       key_broken,
  output logic [7:0] key_data,
  output logic       seq_dropped
);

  state_e      state;
  logic [23:0] timeout_cnt;
  logic [2:0]  skip_cnt;
  logic [7:0]  lut_code;
  logic        is_ext;
  logic        is_break;
  logic        in_prefix;
  logic        lookup_now;
  logic        emit;

  assign is_ext    = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign is_break  = (state == ST_BRK) || (state == ST_EXT_BRK);
  assign in_prefix = (state == ST_EXT) || (state == ST_BRK) || (state == ST_EXT_BRK);

  scancode_lut u_lut (
    .ext     (is_ext),
    .code    (ps2_data),
    .keycode (lut_code)
  );

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] last_make;
`endif

  always_comb begin
    lookup_now = 1'b0;
    unique case (state)
      ST_IDLE:    lookup_now = !(ps2_data == SC_EXT || ps2_data == SC_BRK ||
                                 ps2_data == SC_PAUSE || is_ignored(ps2_data));
      ST_EXT:     lookup_now = (ps2_data != SC_BRK);
      ST_BRK,
      ST_EXT_BRK: lookup_now = 1'b1;
      default:    lookup_now = 1'b0;
    endcase
    emit = ps2_data_stb && !ps2_err && lookup_now && (lut_code != KC_INVALID);
`ifdef TYPEMATIC_FILTER_EN
    if (!is_break && lut_code == last_make) emit = 1'b0;
`endif
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      timeout_cnt  <= '0;
      skip_cnt     <= '0;
      key_data_stb <= 1'b0;
      key_broken   <= 1'b0;
      key_data     <= 8'h00;
      seq_dropped  <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      last_make    <= 8'h00;
`endif
    end else begin
      key_data_stb <= 1'b0;
      seq_dropped  <= 1'b0;
      if (ps2_err) begin
        state       <= ST_IDLE;
        timeout_cnt <= '0;
        skip_cnt    <= '0;
        seq_dropped <= 1'b1;
      end else if (ps2_data_stb) begin
        timeout_cnt <= '0;
        unique case (state)
          ST_IDLE: begin
            if (ps2_data == SC_EXT)        state <= ST_EXT;
            else if (ps2_data == SC_BRK)   state <= ST_BRK;
            else if (ps2_data == SC_PAUSE) begin
              state    <= ST_PAUSE;
              skip_cnt <= PAUSE_SKIP;
            end
          end
          ST_EXT:  state <= (ps2_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
          ST_PAUSE: begin
            if (skip_cnt <= 3'd1) begin
              state    <= ST_IDLE;
              skip_cnt <= '0;
            end else begin
              skip_cnt <= skip_cnt - 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
        if (emit) begin
          key_data_stb <= 1'b1;
          key_data     <= lut_code;
          key_broken   <= is_break;
`ifdef TYPEMATIC_FILTER_EN
          if (!is_break)                   last_make <= lut_code;
          else if (lut_code == last_make)  last_make <= 8'h00;
`endif
        end
      end else if (in_prefix) begin
        // Abandon a prefix whose follow-up byte never arrived
        if (timeout_cnt == PREFIX_TIMEOUT - 24'd1) begin
          state       <= ST_IDLE;
          timeout_cnt <= '0;
          seq_dropped <= 1'b1;
        end else begin
          timeout_cnt <= timeout_cnt + 24'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scancode_converter.sv
// Directed self-checking bench for scancode_converter with a short prefix timeout.
module tb_scancode_converter;

  localparam logic [23:0] TMO = 24'd20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_data_stb = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_err = 1'b0;
  logic       key_data_stb;
  logic       key_broken;
  logic [7:0] key_data;
  logic       seq_dropped;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int base;

  scancode_converter #(.PREFIX_TIMEOUT(TMO), .PAUSE_SKIP(3'd7)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_data_stb (ps2_data_stb),
    .ps2_data     (ps2_data),
    .ps2_err      (ps2_err),
    .key_data_stb (key_data_stb),
    .key_broken   (key_broken),
    .key_data     (key_data),
    .seq_dropped  (seq_dropped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (key_data_stb === 1'b1) stb_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    ps2_data_stb = 1'b1;
    ps2_data     = b;
  endtask

  // Drops the strobe; returns on the negedge where a keycode for the last byte is visible
  task automatic idle();
    @(negedge clk);
    ps2_data_stb = 1'b0;
    ps2_err      = 1'b0;
    #1;
  endtask

  task automatic key(input string tag, input logic [7:0] kd, input logic kb);
    check({tag, "_stb"}, {31'd0, key_data_stb}, 32'd1);
    check({tag, "_data"}, {24'd0, key_data}, {24'd0, kd});
    check({tag, "_brk"}, {31'd0, key_broken}, {31'd0, kb});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_stb", {31'd0, key_data_stb}, 32'd0);
    check("rst_brk", {31'd0, key_broken}, 32'd0);
    check("rst_data", {24'd0, key_data}, 32'h00);
    check("rst_drop", {31'd0, seq_dropped}, 32'd0);
    rst = 1'b0;

    put(8'h1C); idle();
    key("make_a", 8'h01, 1'b0);
    @(negedge clk); #1;
    check("stb_one_cycle", {31'd0, key_data_stb}, 32'd0);

    put(8'hF0); put(8'h1C); idle();
    key("break_a", 8'h01, 1'b1);

    put(8'hE0); put(8'h11); idle();
    key("ext_make_alt", 8'h2F, 1'b0);
    put(8'hE0); put(8'hF0); put(8'h11); idle();
    key("ext_break_alt", 8'h2F, 1'b1);

    base = stb_cnt;
    put(8'hE0); put(8'h12); put(8'hAA); put(8'h00); idle();
    repeat (2) @(negedge clk); #1;
    check("miss_fake_shift_cnt", stb_cnt - base, 0);
    check("miss_hold_data", {24'd0, key_data}, 32'h2F);

    base = stb_cnt;
    put(8'hE1); put(8'h14); put(8'h77); put(8'hE1);
    put(8'hF0); put(8'h14); put(8'hF0); put(8'h77); idle();
    repeat (2) @(negedge clk); #1;
    check("pause_no_stb", stb_cnt - base, 0);
    put(8'h16); idle();
    key("after_pause", 8'h1C, 1'b0);

    put(8'hE0); idle();
    repeat (int'(TMO) - 1) @(negedge clk);
    #1;
    check("tmo_not_early", {31'd0, seq_dropped}, 32'd0);
    @(negedge clk); #1;
    check("tmo_dropped", {31'd0, seq_dropped}, 32'd1);
    put(8'h33); idle();
    key("after_tmo_h", 8'h08, 1'b0);

    base = stb_cnt;
    put(8'hF0);
    put(8'h1C); ps2_err = 1'b1;
    idle();
    check("err_dropped", {31'd0, seq_dropped}, 32'd1);
    check("err_no_stb", {31'd0, key_data_stb}, 32'd0);
    put(8'h29); idle();
    key("after_err_sp", 8'h2A, 1'b0);

    put(8'hF0); idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_stb", {31'd0, key_data_stb}, 32'd0);
    put(8'h1C); idle();
    key("midrst_make", 8'h01, 1'b0);

    base = stb_cnt;
    put(8'h12); put(8'h12); put(8'h12); put(8'hF0); put(8'h12); put(8'h12); idle();
    repeat (2) @(negedge clk); #1;
`ifdef TYPEMATIC_FILTER_EN
    check("typematic_cnt", stb_cnt - base, 3);
`else
    check("typematic_cnt", stb_cnt - base, 5);
`endif
    check("typematic_last_data", {24'd0, key_data}, 32'h2D);
    check("typematic_last_brk", {31'd0, key_broken}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
